vce_scan_doubler: RTL and testbench

//  Sits downstream of the HuC6260 VCE. Takes its 8-bit R/G/B pixel stream plus the VDC sync pair,

---
 rtl/vce_scan_doubler_if.sv | 26 ++
 rtl/vce_scan_doubler.sv | 177 +++++++++++++++++
 tb/tb_vce_scan_doubler.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/vce_scan_doubler_if.sv
// Pixel/sync bundle between the VCE source and the scan doubler, plus the doubled VGA-rate output.
interface vce_scan_doubler_if;
    logic       in_pix_en;
    logic [7:0] in_r;
    logic [7:0] in_g;
    logic [7:0] in_b;
    logic       in_hsync_n;
    logic       in_vsync_n;
    logic [7:0] out_r;
    logic [7:0] out_g;
    logic [7:0] out_b;
    logic       out_hsync_n;
    logic       out_vsync_n;
    logic       out_de;
    logic       out_locked;

    modport master (
        output in_pix_en, in_r, in_g, in_b, in_hsync_n, in_vsync_n,
        input  out_r, out_g, out_b, out_hsync_n, out_vsync_n, out_de, out_locked
    );

    modport slave (
        input  in_pix_en, in_r, in_g, in_b, in_hsync_n, in_vsync_n,
        output out_r, out_g, out_b, out_hsync_n, out_vsync_n, out_de, out_locked
    );
endinterface

// File: rtl/vce_scan_doubler.sv
// Line doubler for the HuC6260 VCE: captures one input line into a ping-pong RAM and replays it
// twice at 2x line rate. Build macro SCANLINES_EN halves the intensity of the second replay.
module vce_scan_doubler #(
    parameter int H_ACTIVE   = 256,
    parameter int LINE_W     = 12,
    parameter int OUT_HSTART = 64,
    parameter int HSYNC_W    = 48
) (
    input  logic              clk,
    input  logic              reset_N,
    vce_scan_doubler_if.slave bus
);
    localparam int XW = $clog2(H_ACTIVE);
    localparam int CW = $clog2(H_ACTIVE + 1);
    localparam logic [CW-1:0]     X_MAX  = CW'(H_ACTIVE);
    localparam logic [LINE_W-1:0] HS_END = LINE_W'(HSYNC_W);
    localparam logic [LINE_W-1:0] DE_BEG = LINE_W'(OUT_HSTART);
    localparam logic [LINE_W-1:0] DE_END = LINE_W'(OUT_HSTART + H_ACTIVE);

    typedef enum logic [1:0] { WAIT_LOCK, LINE_A, LINE_B } state_t;

    logic              hs_q, hs_prev, vs_q, line_edge;
    logic              bank_sel, wr_bank, wr_en;
    logic [CW-1:0]     wr_x, wr_x_eff, wr_count;
    logic [LINE_W-1:0] period_cnt, line_len, half;
    state_t            state, state_nx;
    logic [LINE_W-1:0] out_h, out_h_nx, x_full;
    logic              seen_edge, seen_edge_nx, locked, locked_nx, vs_line, vs_line_nx;
    logic              hs_act, de_act, x_ok;
    logic [23:0]       line_ram [2*H_ACTIVE];
    logic [23:0]       rd_data, pix;
    logic              p1_hs, p1_de, p1_ok, p1_vs;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            hs_q    <= 1'b1;
            hs_prev <= 1'b1;
            vs_q    <= 1'b1;
        end else begin
            hs_q    <= bus.in_hsync_n;
            hs_prev <= hs_q;
            vs_q    <= bus.in_vsync_n;
        end
    end

    assign line_edge = hs_prev & ~hs_q;

    // A strobe on the edge cycle already belongs to the new line, in the bank about to become write bank.
    assign wr_x_eff = line_edge ? '0 : wr_x;
    assign wr_bank  = line_edge ? ~bank_sel : bank_sel;
    assign wr_en    = bus.in_pix_en && (wr_x_eff < X_MAX);

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            bank_sel <= 1'b0;
            wr_x     <= '0;
            wr_count <= '0;
        end else begin
            if (line_edge) begin
                bank_sel <= ~bank_sel;
                wr_count <= wr_x;
            end
            wr_x <= wr_en ? wr_x_eff + CW'(1) : wr_x_eff;
        end
    end

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            period_cnt <= '0;
            line_len   <= '0;
        end else if (line_edge) begin
            line_len   <= period_cnt;
            period_cnt <= LINE_W'(1);
        end else if (period_cnt != '1) begin
            period_cnt <= period_cnt + LINE_W'(1);
        end
    end

    assign half = line_len >> 1;

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state     <= WAIT_LOCK;
            out_h     <= '0;
            seen_edge <= 1'b0;
            locked    <= 1'b0;
            vs_line   <= 1'b1;
        end else begin
            state     <= state_nx;
            out_h     <= out_h_nx;
            seen_edge <= seen_edge_nx;
            locked    <= locked_nx;
            vs_line   <= vs_line_nx;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nx     = state;
        out_h_nx     = out_h;
        seen_edge_nx = seen_edge;
        locked_nx    = locked;
        vs_line_nx   = vs_line;
        if (line_edge) begin
            seen_edge_nx = 1'b1;
            if (state != WAIT_LOCK || seen_edge) begin
                state_nx   = LINE_A;
                out_h_nx   = '0;
                locked_nx  = 1'b1;
                vs_line_nx = vs_q;
            end
        end else begin
            case (state)
                LINE_A: begin
                    if (out_h + LINE_W'(1) >= half) begin
                        state_nx = LINE_B;
                        out_h_nx = '0;
                    end else begin
                        out_h_nx = out_h + LINE_W'(1);
                    end
                end
                LINE_B:  if (out_h != '1) out_h_nx = out_h + LINE_W'(1);
                default: ;
            endcase
        end
    end

    assign hs_act = (state != WAIT_LOCK) && (out_h < HS_END);
    assign de_act = (state != WAIT_LOCK) && (out_h >= DE_BEG) && (out_h < DE_END);
    assign x_full = out_h - DE_BEG;
    assign x_ok   = x_full < LINE_W'(wr_count);

    // NOTE: the line RAM is deliberately not reset; wr_count masks any stale contents on replay.
    always_ff @(posedge clk) begin
        if (wr_en) line_ram[{wr_bank, wr_x_eff[XW-1:0]}] <= {bus.in_r, bus.in_g, bus.in_b};
        rd_data <= line_ram[{~bank_sel, x_full[XW-1:0]}];
    end

`ifdef SCANLINES_EN
    logic p1_lb;
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) p1_lb <= 1'b0;
        else          p1_lb <= (state == LINE_B);
    end
    assign pix = p1_lb ? {1'b0, rd_data[23:17], 1'b0, rd_data[15:9], 1'b0, rd_data[7:1]} : rd_data;
`else
    assign pix = rd_data;
`endif

    // Stage 1 carries the timing flags alongside the RAM read; stage 2 registers the outputs.
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            p1_hs           <= 1'b0;
            p1_de           <= 1'b0;
            p1_ok           <= 1'b0;
            p1_vs           <= 1'b1;
            bus.out_r       <= '0;
            bus.out_g       <= '0;
            bus.out_b       <= '0;
            bus.out_hsync_n <= 1'b1;
            bus.out_vsync_n <= 1'b1;
            bus.out_de      <= 1'b0;
        end else begin
            p1_hs           <= hs_act;
            p1_de           <= de_act;
            p1_ok           <= x_ok;
            p1_vs           <= vs_line;
            bus.out_hsync_n <= ~p1_hs;
            bus.out_vsync_n <= p1_vs;
            bus.out_de      <= p1_de;
            {bus.out_r, bus.out_g, bus.out_b} <= (p1_de && p1_ok) ? pix : 24'h0;
        end
    end

    assign bus.out_locked = locked;
endmodule

// File: tb/tb_vce_scan_doubler.sv
// Directed bench for vce_scan_doubler: drives VCE-rate lines, queues the expected doubled output
// and compares pixels, sync widths, line lengths and vsync as the DUT emits them.
module tb_vce_scan_doubler;
    localparam int PERIOD   = 1364;
    localparam int H_ACTIVE = 256;

    logic clk = 1'b0;
    logic reset_N;

    vce_scan_doubler_if bus ();

    vce_scan_doubler dut (
        .clk     (clk),
        .reset_N (reset_N),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [23:0] pix_q [$];
    logic        vs_q  [$];
    int          len_q [$];
    int          cyc, line_start, de_start, de_cnt, line_no, prev_period;
    bit          have_line, prev_hs, prev_de;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] pix(input int mode, input int base, input int x);
        logic [7:0] r;
        r = 8'(x + base) ^ ((x >= H_ACTIVE) ? 8'h3C : 8'h00);
        return (mode == 1) ? 24'hFFFFFF : {r, r ^ 8'hA5, ~r};
    endfunction

    task automatic monitor();
        logic [23:0] exp_px;
        int          exp_len;
        logic        exp_vs;
        cyc++;
        if (bus.out_de) begin
            de_cnt++;
            if (pix_q.size() == 0) begin
                check("de_unexpected", 32'(bus.out_de), 32'd0);
            end else begin
                exp_px = pix_q.pop_front();
                check("pixel", {bus.out_r, bus.out_g, bus.out_b}, exp_px);
            end
        end else begin
            check("blank_rgb", {bus.out_r, bus.out_g, bus.out_b}, 24'h0);
        end
        if (prev_hs && !bus.out_hsync_n) begin
            if (have_line) begin
                exp_len = -1;
                if (len_q.size() != 0) exp_len = len_q.pop_front();
                check("line_len", cyc - line_start, exp_len);
            end
            exp_vs = 1'bx;
            if (vs_q.size() != 0) exp_vs = vs_q.pop_front();
            check("vsync", 32'(bus.out_vsync_n), 32'(exp_vs));
            line_start = cyc;
            have_line  = 1'b1;
        end
        if (!prev_hs && bus.out_hsync_n && have_line) check("hsync_width", cyc - line_start, 48);
        if (!prev_de && bus.out_de) begin
            check("de_offset", cyc - line_start, 64);
            de_start = cyc;
        end
        if (prev_de && !bus.out_de) check("de_width", cyc - de_start, H_ACTIVE);
        prev_hs = bus.out_hsync_n;
        prev_de = bus.out_de;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        monitor();
    endtask

    task automatic check_reset_outputs();
        check("rst_rgb", {bus.out_r, bus.out_g, bus.out_b}, 24'h0);
        check("rst_hsync", 32'(bus.out_hsync_n), 32'd1);
        check("rst_vsync", 32'(bus.out_vsync_n), 32'd1);
        check("rst_de", 32'(bus.out_de), 32'd0);
        check("rst_locked", 32'(bus.out_locked), 32'd0);
    endtask

    // One input line: hsync falls at slot 0, strobes every 4 clk from slot 'first'. Its own
    // replay is queued unless 'last'; the output pair started by its edge gets vsync/lengths queued.
    task automatic drive_line(input int period, input int npx, input int first, input int mode,
                              input int base, input logic vs, input bit last);
        logic [23:0] e;
        line_no++;
        if (!last) begin
            for (int x = 0; x < H_ACTIVE; x++) pix_q.push_back(x < npx ? pix(mode, base, x) : 24'h0);
            for (int x = 0; x < H_ACTIVE; x++) begin
                e = (x < npx) ? pix(mode, base, x) : 24'h0;
`ifdef SCANLINES_EN
                e = (e >> 1) & 24'h7F7F7F;
`endif
                pix_q.push_back(e);
            end
        end
        if (line_no >= 2) begin
            vs_q.push_back(vs);
            vs_q.push_back(vs);
            len_q.push_back(prev_period / 2);
            len_q.push_back(period - prev_period / 2);
        end
        prev_period = period;
        bus.in_vsync_n = vs;
        for (int s = 0; s < period; s++) begin
            bus.in_hsync_n = (s >= 16);
            if (s >= first && (s - first) % 4 == 0 && (s - first) / 4 < npx) begin
                bus.in_pix_en = 1'b1;
                {bus.in_r, bus.in_g, bus.in_b} = pix(mode, base, (s - first) / 4);
            end else begin
                bus.in_pix_en = 1'b0;
            end
            tick();
        end
    endtask

    initial begin
        bus.in_pix_en  = 1'b0;
        bus.in_r       = '0;
        bus.in_g       = '0;
        bus.in_b       = '0;
        bus.in_hsync_n = 1'b1;
        bus.in_vsync_n = 1'b1;
        reset_N        = 1'b0;
        cyc = 0; line_start = 0; de_start = 0; de_cnt = 0; line_no = 0; prev_period = 0;
        have_line = 1'b0; prev_hs = 1'b1; prev_de = 1'b0;

        repeat (4) tick();
        check_reset_outputs();
        reset_N = 1'b1;
        tick();

        // A single edge must not lock; the second one starts replay of the line between them.
        drive_line(PERIOD, 256, 8, 0, 0, 1'b1, 1'b0);
        check("locked_one_edge", 32'(bus.out_locked), 32'd0);
        check("de_before_lock", de_cnt, 0);
        drive_line(PERIOD, 256, 8, 0, 1, 1'b1, 1'b0);
        check("locked_two_edges", 32'(bus.out_locked), 32'd1);

        drive_line(PERIOD, 100, 8, 0, 3, 1'b1, 1'b0);
        drive_line(PERIOD, 300, 8, 0, 7, 1'b1, 1'b0);
        drive_line(PERIOD + 1, 256, 1, 0, 11, 1'b1, 1'b0);
        drive_line(PERIOD + 1, 256, 8, 1, 0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) drive_line(PERIOD, 256, 8, 0, 20 + k, 1'b0, 1'b0);
        drive_line(PERIOD, 256, 8, 0, 23, 1'b1, 1'b0);
        drive_line(PERIOD, 0, 8, 0, 0, 1'b1, 1'b1);
        check("pixels_drained", pix_q.size(), 0);
        check("vsync_drained", vs_q.size(), 0);

        // Reset while the output sits in LINE_B and a new input line is half written.
        for (int s = 0; s < 300; s++) begin
            bus.in_pix_en = (s % 4 == 0) && (s < 160);
            {bus.in_r, bus.in_g, bus.in_b} = {8'(s), 8'(s), 8'(s)};
            tick();
        end
        bus.in_pix_en = 1'b0;
        reset_N = 1'b0;
        tick();
        tick();
        check_reset_outputs();
        pix_q.delete();
        vs_q.delete();
        len_q.delete();
        line_no = 0; de_cnt = 0; have_line = 1'b0; prev_hs = 1'b1; prev_de = 1'b0;
        reset_N = 1'b1;
        tick();

        drive_line(PERIOD, 20, 8, 0, 40, 1'b1, 1'b0);
        check("relock_one_edge", 32'(bus.out_locked), 32'd0);
        check("relock_no_de", de_cnt, 0);
        drive_line(PERIOD, 0, 8, 0, 0, 1'b1, 1'b1);
        check("relock_two_edges", 32'(bus.out_locked), 32'd1);
        check("relock_pixels_drained", pix_q.size(), 0);
        check("relock_vsync_drained", vs_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
